// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised register file, DATA_W x 2**ADDR_W entries,
// NUM_RD independent registered read ports and one write port.
// Reads have a latency of one cycle, a per-port valid and write-to-read bypass.
// Synchronous active-high reset loads a one-hot pattern: entry i = 1 << (i mod DATA_W).
// Optional build macro REGFILE_ZERO_REG_EN: entry 0 is hardwired to zero,
// writes to address 0 are dropped and reads of address 0 always return zero.
module regfile_multiport #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word [NUM_RD];
  logic              wr_ok;

  // A write to the zero register is discarded, so it must not commit or bypass
`ifdef REGFILE_ZERO_REG_EN
  assign wr_ok = wr_en && (wr_addr != '0);
`else
  assign wr_ok = wr_en;
`endif

  // Per-port read word: fresh write data wins over the stored entry
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      if (wr_ok && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_word[k] = wr_data;
      end else begin
        rd_word[k] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
      end
`ifdef REGFILE_ZERO_REG_EN
      if (rd_addr[k*ADDR_W +: ADDR_W] == '0) begin
        rd_word[k] = '0;
      end
`endif
    end
  end

  // Storage array: one-hot reset pattern, single write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(1) << (i % DATA_W);
      end
`ifdef REGFILE_ZERO_REG_EN
      mem[0] <= '0;
`endif
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read ports: idle ports drop valid but keep their last data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        rd_valid[k] <= rd_en[k];
        if (rd_en[k]) begin
          rd_data[k*DATA_W +: DATA_W] <= rd_word[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Testbench for regfile_multiport: directed scenarios plus a randomized run,
// all checked against an array-based reference model of the register file.
module tb_regfile_multiport;

  localparam int DW    = 4;
  localparam int AW    = 2;
  localparam int NR    = 2;
  localparam int DEPTH = 2 ** AW;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_valid;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem    [DEPTH];
  logic [DW-1:0] exp_data [NR];
  logic [NR-1:0] exp_valid;

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] port_data(int k);
    return rd_data[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] reset_val(int i);
    logic [DW-1:0] one;
    one = 1;
    if (ZR && i == 0) return '0;
    return one << (i % DW);
  endfunction

  task automatic set_rd(int k, logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; rd_en = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  // Advance one clock; the model applies the register file's rules to the
  // inputs as they stood at the edge, then outputs are sampled 1ns later.
  task automatic tick();
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = reset_val(i);
      for (int k = 0; k < NR; k++) exp_data[k] = '0;
      exp_valid = '0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (rd_en[k]) begin
          a = rd_addr[k*AW +: AW];
          v = (wr_en && wr_addr == a) ? wr_data : m_mem[a];
          if (ZR && a == 0) v = '0;
          exp_data[k]  = v;
          exp_valid[k] = 1'b1;
        end else begin
          exp_valid[k] = 1'b0;
        end
      end
      if (wr_en && !(ZR && wr_addr == 0)) m_mem[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; rd_en = '1; set_rd(0, 2'd3); set_rd(1, 2'd1);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'hf;
    tick();
    idle_inputs();
    total++;
    if (rd_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", rd_valid); end
    total++;
    if (rd_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", rd_data); end
  endtask

  task automatic test_reset_read();
    logic [DW-1:0] want;
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 2'b11; set_rd(0, AW'(a)); set_rd(1, AW'(a));
      tick();
      want = reset_val(a);
      for (int k = 0; k < NR; k++) begin
        total++;
        if (rd_valid[k] !== 1'b1 || port_data(k) !== want) begin
          bad++;
          $display("FAIL reset_read a=%0d port=%0d got=%b/%b exp=1/%b", a, k, rd_valid[k], port_data(k), want);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'b1010;
    tick();
    idle_inputs();
    rd_en = 2'b01; set_rd(0, 2'd2);
    tick();
    idle_inputs();
    total++;
    if (rd_valid[0] !== 1'b1 || port_data(0) !== 4'b1010) begin
      bad++; $display("FAIL write_read got=%b/%b exp=1/1010", rd_valid[0], port_data(0));
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'b0111;
    rd_en = 2'b11; set_rd(0, 2'd3); set_rd(1, 2'd1);
    tick();
    idle_inputs();
    total++;
    if (port_data(0) !== 4'b0111) begin bad++; $display("FAIL bypass_p0 got=%b exp=0111", port_data(0)); end
    total++;
    if (port_data(1) !== reset_val(1)) begin bad++; $display("FAIL bypass_p1 got=%b exp=%b", port_data(1), reset_val(1)); end
    total++;
    if (rd_valid !== 2'b11) begin bad++; $display("FAIL bypass_valid got=%b exp=11", rd_valid); end
  endtask

  task automatic test_idle_hold();
    rst = 1'b1;
    tick();
    idle_inputs();
    rd_en = 2'b10; set_rd(1, 2'd2);
    tick();
    idle_inputs();
    total++;
    if (rd_valid[1] !== 1'b1 || port_data(1) !== 4'b0100) begin
      bad++; $display("FAIL idle_first got=%b/%b exp=1/0100", rd_valid[1], port_data(1));
    end
    set_rd(1, 2'd3);
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (rd_valid[1] !== 1'b0 || port_data(1) !== 4'b0100) begin
        bad++; $display("FAIL idle_hold cyc=%0d got=%b/%b exp=0/0100", c, rd_valid[1], port_data(1));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 2'b01; set_rd(0, AW'(DEPTH - 1 - a));
      tick();
      total++;
      if (rd_valid[0] !== 1'b1 || port_data(0) !== m_mem[DEPTH - 1 - a]) begin
        bad++; $display("FAIL back_to_back a=%0d got=%b/%b exp=1/%b", DEPTH - 1 - a, rd_valid[0], port_data(0), m_mem[DEPTH - 1 - a]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midstream();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'b1111;
    rd_en = 2'b11; set_rd(0, 2'd1); set_rd(1, 2'd1);
    tick();
    total++;
    if (rd_valid !== 2'b11 || rd_data !== 8'hff) begin
      bad++; $display("FAIL mid_pre got=%b/%h exp=11/ff", rd_valid, rd_data);
    end
    wr_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (rd_valid !== 2'b00 || rd_data !== '0) begin
      bad++; $display("FAIL mid_rst got=%b/%h exp=00/00", rd_valid, rd_data);
    end
    tick();
    idle_inputs();
    total++;
    if (rd_valid !== 2'b11 || port_data(0) !== 4'b0010 || port_data(1) !== 4'b0010) begin
      bad++; $display("FAIL mid_after got=%b/%h exp=11/22", rd_valid, rd_data);
    end
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] want;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'b1100;
    tick();
    idle_inputs();
    rd_en = 2'b01; set_rd(0, 2'd0);
    tick();
    want = ZR ? 4'b0000 : 4'b1100;
    total++;
    if (port_data(0) !== want) begin bad++; $display("FAIL zero_read got=%b exp=%b", port_data(0), want); end
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'b1001;
    rd_en = 2'b11; set_rd(0, 2'd0); set_rd(1, 2'd0);
    tick();
    idle_inputs();
    want = ZR ? 4'b0000 : 4'b1001;
    for (int k = 0; k < NR; k++) begin
      total++;
      if (port_data(k) !== want) begin bad++; $display("FAIL zero_bypass port=%0d got=%b exp=%b", k, port_data(k), want); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(31) == 0);
      rd_en   = NR'($urandom);
      rd_addr = (NR*AW)'($urandom);
      wr_en   = $urandom_range(1);
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      tick();
      for (int k = 0; k < NR; k++) begin
        total++;
        if (rd_valid[k] !== exp_valid[k] || port_data(k) !== exp_data[k]) begin
          bad++;
          $display("FAIL random cyc=%0d port=%0d got=%b/%b exp=%b/%b", c, k, rd_valid[k], port_data(k), exp_valid[k], exp_data[k]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int k = 0; k < NR; k++) exp_data[k] = '0;
    exp_valid = '0;
    #2;
    test_reset();
    test_reset_read();
    test_write_read();
    test_bypass();
    test_idle_hold();
    test_back_to_back();
    test_reset_midstream();
    test_zero_reg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised register file, successor to the fixed 4x4 two-read/one-write file in the simple CPU datapath. Generalised in word width, depth and read-port count. Adds:
- registered (1-cycle) reads with per-port enable and valid;
- write-to-read bypass;
- synchronous reset to a defined one-hot pattern.

Sits between decode (addresses) and ALU (operands); writeback drives the write port.

Parameters:
DATA_W, 4, word width in bits (>=1)
ADDR_W, 2, address width; depth = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..8)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset; synchronous, active-high
rd_en  in  NUM_RD  per-port read request; bit k = port k
rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data; port k at [k*DATA_W +: DATA_W]
rd_valid  out  NUM_RD  bit k high for one cycle when rd_data port k carries a fresh result
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data

Behaviour:
- Reset (rst=1 at rising clk edge):
  - entry i <= 1 << (i mod DATA_W); defaults give 0001, 0010, 0100, 1000;
  - rd_data all 0; rd_valid all 0;
  - read and write requests in that cycle are ignored.
- rst takes priority over everything, including mid-operation: a read issued in the cycle before reset completes normally only if its result edge is not a reset edge; otherwise rd_valid stays 0.
- Write: wr_en=1 at edge -> entry[wr_addr] <= wr_data. Visible to array reads from the next cycle.
- Read, port k, rd_en[k]=1 at edge N:
  - at edge N, rd_data_k <= entry[rd_addr_k] and rd_valid[k] <= 1;
  - result is visible during cycle N+1; latency 1 cycle.
- Bypass: if at edge N wr_en=1 and wr_addr==rd_addr_k, rd_data_k <= wr_data (new value), not the old array content.
- Idle port: rd_en[k]=0 -> rd_valid[k] <= 0; rd_data_k holds its previous value.
- Ports are fully independent:
  - any number of ports may read the same address in the same cycle;
  - each port bypasses independently.
- Back-to-back reads on one port: rd_valid stays high; each cycle's data reflects that cycle's address.
- Address wrap: addresses are exactly ADDR_W bits; no out-of-range case exists.
- Data width: writes store all DATA_W bits; no truncation or extension.
- No combinational path from any input to any output; all outputs are registers.

Optional Feature:
Macro REGFILE_ZERO_REG_EN.
- Defined:
  - entry 0 is hardwired to all-zero; its reset value is 0, not 1;
  - writes to address 0 are discarded;
  - reads of address 0 return 0, including the bypass case (write to 0 in the same cycle still reads 0).
- Not defined: entry 0 is an ordinary register, reset to 1 (bit 0 set), writable and bypassed like all others.

Test Plan:
1. Reset then read all entries, one address per cycle on both ports (defaults) -> data 0001, 0010, 0100, 1000 (entry 0 reads 0000 with REGFILE_ZERO_REG_EN), each with rd_valid=1 one cycle after request.
2. Write addr 2 = 1010; next cycle read addr 2 on port 0 -> rd_data_0=1010 one cycle later, rd_valid[0]=1.
3. Same edge: wr_en=1, addr 3, data 0111; port 0 reads 3; port 1 reads 1 -> port 0 = 0111 (bypass), port 1 = 0010.
4. rd_en=0 on port 1 for 3 cycles after a read of 0100 -> rd_valid[1]=0, rd_data_1 holds 0100 throughout.
5. Write addr 1 = 1111, then assert rst mid-stream with rd_en=11 -> following cycle rd_valid=00 and rd_data=0; subsequent read of addr 1 returns 0010.
6. Write addr 0 = 1100, then read addr 0 -> 1100 without macro; 0000 with REGFILE_ZERO_REG_EN, including the same-cycle bypass attempt.
